// File: rtl/dff_pipeline.sv
// dff_pipeline: elastic chain of DEPTH register stages with per-stage valid bits.
// Empty stages always accept, so bubbles collapse under backpressure. A
// synchronous flush and an asynchronous reset both empty the chain. A registered
// occupancy counter tracks how many stages currently hold a word.
module dff_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [OCC_W-1:0] occupancy
);

  // Flattened view of every stage's valid bit and data word.
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];

  // Per-stage ready: rdy[i] = !v[i] | rdy[i+1], ending in out_ready.
  // Unrolled, a stage is ready when out_ready is high or any stage from i
  // to the output is empty. Computing it that way keeps the logic free of
  // a self-referencing chain through a single vector.
  logic [DEPTH-1:0] w_rdy;

  // Handshake strobes used by the occupancy counter.
  logic w_push;
  logic w_pop;

  logic [OCC_W-1:0] r_occupancy;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             r_v;
      logic [WIDTH-1:0] r_d;
      logic             w_up_v;
      logic [WIDTH-1:0] w_up_d;

      // Stage 0 is fed by the producer; later stages by their predecessor.
      if (gi == 0) begin : g_first
        assign w_up_v = in_valid;
        assign w_up_d = data_in;
      end else begin : g_chain
        assign w_up_v = w_v[gi-1];
        assign w_up_d = w_d[gi-1];
      end

      assign w_rdy[gi] = out_ready | ~(&w_v[DEPTH-1:gi]);
      assign w_v[gi]   = r_v;
      assign w_d[gi]   = r_d;

      // Stage register: clear on reset/flush, else load from upstream when ready.
      // Data is only overwritten by a valid word so an emptied stage keeps
      // its last contents visible.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_v <= 1'b0;
          r_d <= RESET_VALUE;
        end else if (flush) begin
          r_v <= 1'b0;
          r_d <= RESET_VALUE;
        end else if (w_rdy[gi]) begin
          r_v <= w_up_v;
          if (w_up_v) begin
            r_d <= w_up_d;
          end
        end
      end
    end
  endgenerate

  // Flush masks both handshakes so nothing enters or leaves during it.
  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = w_v[DEPTH-1] & ~flush;
  assign data_out  = w_d[DEPTH-1];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Occupancy counter: +1 on push only, -1 on pop only, cleared by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occupancy <= '0;
    end else if (flush) begin
      r_occupancy <= '0;
    end else if (w_push && !w_pop) begin
      r_occupancy <= r_occupancy + OCC_W'(1);
    end else if (w_pop && !w_push) begin
      r_occupancy <= r_occupancy - OCC_W'(1);
    end
  end

  assign occupancy = r_occupancy;

endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: directed and random stimulus for dff_pipeline, checked
// against a token-queue model (each in-flight word carries its stage index).
module tb_dff_pipeline;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'h5A;

  logic             clock     = 1'b0;
  logic             reset     = 1'b1;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] data_in   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic [2:0]       occupancy;

  int total = 0;
  int bad   = 0;

  // Model: words in flight, oldest first, with the stage each one sits in.
  int         q_pos[$];
  logic [7:0] q_dat[$];
  logic [7:0] m_dout = RV;

  dff_pipeline #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .RESET_VALUE(RV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q_pos.delete();
    q_dat.delete();
    m_dout = RV;
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model.
  // An occupied word moves forward when out_ready is high, or when the
  // stages in front of it hold fewer words than there are stages.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic e_ir;
    logic e_ov;
    logic push;
    logic pop;
    int   n;
    @(negedge clock);
    in_valid  = iv;
    data_in   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    n    = q_pos.size();
    e_ir = !fl && (n < DEPTH || ordy);
    e_ov = !fl && n > 0 && q_pos[0] == DEPTH - 1;
    chk("in_ready",  {31'b0, in_ready},  {31'b0, e_ir});
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    chk("data_out",  {24'b0, data_out},  {24'b0, m_dout});
    chk("occupancy", {29'b0, occupancy}, 32'(n));
    push = iv && e_ir;
    pop  = e_ov && ordy;
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else begin
      if (pop) begin
        $display("out word %02h at %0t", q_dat[0], $time);
        void'(q_pos.pop_front());
        void'(q_dat.pop_front());
      end
      for (int j = 0; j < q_pos.size(); j++) begin
        if (ordy || (j < DEPTH - 1 - q_pos[j])) begin
          q_pos[j] = q_pos[j] + 1;
          if (q_pos[j] == DEPTH - 1) m_dout = q_dat[j];
        end
      end
      if (push) begin
        q_pos.push_back(0);
        q_dat.push_back(id);
      end
    end
  endtask

  initial begin
    // Power-on reset, released away from the clock edge.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Latency: single word with out_ready held high.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill with out_ready low, observe stall, then drain.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous streaming of 0x01..0x20.
    for (int k = 1; k <= 32; k++) step(1'b1, 8'(k), 1'b1, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random valid gaps and out_ready toggling, with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));
    end
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with three words in flight, oldest at the output stage.
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hC4, 1'b0, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-cycle while full and out_ready high.
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0);
    step(1'b1, 8'hB4, 1'b0, 1'b0);
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data_out",  {24'b0, data_out},  {24'b0, RV});
    chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
